mem_access_ctrl: RTL and testbench

CPU-side memory access controller sitting directly upstream of the byte-addressable RAM (`ram256x8`). It accepts one load/store request at a time from the datapath and drives the RAM's MOV/ReadWrite/MS_2_0/Address/DataIn handshake. It waits for MOC, then sign- or zero-extends loaded data and returns a one-cycle response with status. It replaces the ad-hoc CPU state sequencing used to exercise the RAM today.

---
 rtl/mem_access_ctrl_pkg.sv | 31 +++
 rtl/mem_access_ctrl_if.sv | 32 +++
 rtl/mem_access_ctrl_load_extend.sv | 21 ++
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the CPU-side memory access controller: FSM states,
// access-size codes, response error codes and a size-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] MS_BYTE    = 2'b00;
  localparam logic [1:0] MS_HALF    = 2'b01;
  localparam logic [1:0] MS_WORD    = 2'b10;
  localparam logic [1:0] MS_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SIZE    = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] ms);
    case (ms)
      MS_BYTE: return 3'd1;
      MS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the CPU request/response handshake and the ram256x8 MOV/MOC bus.
// slave = the controller's view, master = the CPU datapath plus RAM side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_ms;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        MOC;
  logic [31:0] DataOut;

  modport slave (
    input  req_valid, req_write, req_ms, req_addr, req_wdata, MOC, DataOut,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           MOV, ReadWrite, MS_2_0, Address, DataIn
  );

  modport master (
    output req_valid, req_write, req_ms, req_addr, req_wdata, MOC, DataOut,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           MOV, ReadWrite, MS_2_0, Address, DataIn
  );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational sign/zero extension of RAM read data according to the
// access size (ms[1:0]) and signed-load flag (ms[2]).
module mem_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  i_ms,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_ms[1:0])
      MS_BYTE: o_data = {{24{i_ms[2] & i_data[7]}},  i_data[7:0]};
      MS_HALF: o_data = {{16{i_ms[2] & i_data[15]}}, i_data[15:0]};
      MS_WORD: o_data = i_data;
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// One-at-a-time load/store controller driving the ram256x8 MOV/MOC handshake.
// Optional MOC wait timeout is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_LIMIT     = 256,
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic         CLK,
  input  logic         RST_N,
  mem_access_ctrl_if.slave bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_write;
  logic [2:0]  r_ms;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_dout;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_err;

  logic        w_ready;
  logic        w_mov;
  logic        w_rsp_valid;
  logic [1:0]  w_rsp_err;
  logic [31:0] w_rsp_rdata;
  logic [31:0] w_ext;
  logic [32:0] w_end;
  logic        w_timeout;

  // 33-bit end address so requests near 2^32 cannot wrap back into range.
  assign w_end = {1'b0, bus.req_addr} + 33'(size_bytes(bus.req_ms[1:0])) - 33'd1;

  mem_load_extend u_ext (
    .i_ms   (r_ms),
    .i_data (r_dout),
    .o_data (w_ext)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_tmo_cnt <= '0;
    else if (w_state_next != r_state)
      r_tmo_cnt <= '0;
    else if (r_state == ST_ACCESS || r_state == ST_RELEASE)
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // Fires on the edge that closes the TIMEOUT_CYCLES-th waiting cycle.
  assign w_timeout = (r_state == ST_ACCESS || r_state == ST_RELEASE) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_mov        = 1'b0;
    w_rsp_valid  = 1'b0;
    w_rsp_err    = ERR_OK;
    w_rsp_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_ms[1:0] == MS_ILLEGAL) begin
            w_state_next = ST_RESP;
            w_rsp_err    = ERR_SIZE;
          end else if (w_end >= 33'(ADDR_LIMIT)) begin
            w_state_next = ST_RESP;
            w_rsp_err    = ERR_RANGE;
          end else begin
            w_state_next = ST_SETUP;
          end
        end
      end
      ST_SETUP: w_state_next = ST_ACCESS;
      ST_ACCESS: begin
        w_mov = 1'b1;
        if (bus.MOC) begin
          w_state_next = ST_RELEASE;
        end else if (w_timeout) begin
          w_state_next = ST_RESP;
          w_rsp_err    = ERR_TIMEOUT;
        end
      end
      ST_RELEASE: begin
        if (!bus.MOC) begin
          w_state_next = ST_RESP;
          w_rsp_rdata  = r_write ? 32'd0 : w_ext;
        end else if (w_timeout) begin
          w_state_next = ST_RESP;
          w_rsp_err    = ERR_TIMEOUT;
        end
      end
      ST_RESP: begin
        w_rsp_valid  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_write     <= 1'b0;
      r_ms        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_dout      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid) begin
        r_write <= bus.req_write;
        r_ms    <= bus.req_ms;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == ST_ACCESS && bus.MOC)
        r_dout <= bus.DataOut;
      // Response fields only change on entry to RESP and hold afterwards.
      if (w_state_next == ST_RESP) begin
        r_rsp_err   <= w_rsp_err;
        r_rsp_rdata <= w_rsp_rdata;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.MOV       = w_mov;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.ReadWrite = ~r_write;
  assign bus.MS_2_0    = r_ms;
  assign bus.Address   = r_addr;
  assign bus.DataIn    = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset abort,
// optional MEM_TIMEOUT_EN case and randomized traffic against a byte-array model.
module tb_mem_access_ctrl;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.ADDR_LIMIT(256), .TIMEOUT_CYCLES(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  int moc_delay = 0;
  int rel_delay = 0;
  bit ram_stuck = 1'b0;

  typedef struct {
    bit          w;
    logic [2:0]  ms;
    logic [31:0] addr;
    logic [31:0] wd;
    int          md;
    int          rd;
    bit          hold;
    logic [1:0]  err;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Big-endian byte-array reference: returns error code and extended load data.
  function automatic void model(input bit w, input logic [2:0] ms, input logic [31:0] a,
                                input logic [31:0] wd, output logic [1:0] err,
                                output logic [31:0] rd);
    int     nb;
    longint last;
    longint v;
    rd  = 32'd0;
    err = 2'b00;
    if (ms[1:0] == 2'b11) begin
      err = 2'b11;
      return;
    end
    nb   = 1 << ms[1:0];
    last = longint'({32'd0, a}) + nb - 1;
    if (last >= 256) begin
      err = 2'b01;
      return;
    end
    if (w) begin
      for (int i = 0; i < nb; i++)
        ref_mem[int'(a[7:0]) + i] = 8'(wd >> (8 * (nb - 1 - i)));
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++)
        v = v * 256 + longint'(ref_mem[int'(a[7:0]) + i]);
      if (ms[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v = v - (longint'(1) << (8 * nb));
      rd = v[31:0];
    end
  endfunction

  // RAM stub: raises MOC moc_delay cycles into MOV, drops it rel_delay cycles after.
  initial begin : ram_stub
    int          cnt;
    int          nb;
    logic [31:0] val;
    logic [7:0]  ab;
    bus.MOC     = 1'b0;
    bus.DataOut = 32'd0;
    cnt         = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        bus.MOC = 1'b0;
        cnt     = 0;
      end else if (bus.MOV && !bus.MOC) begin
        if (!ram_stuck && cnt >= moc_delay) begin
          ab = bus.Address[7:0];
          nb = (bus.MS_2_0[1:0] == 2'b00) ? 1 : (bus.MS_2_0[1:0] == 2'b01) ? 2 : 4;
          if (!bus.ReadWrite) begin
            for (int i = 0; i < nb; i++)
              ram_mem[ab + 8'(i)] = bus.DataIn[8 * (nb - 1 - i) +: 8];
          end else begin
            val = 32'd0;
            for (int i = 0; i < nb; i++)
              val = {val[23:0], ram_mem[ab + 8'(i)]};
            if (nb < 4)
              val = ($urandom() << (8 * nb)) | val;
            bus.DataOut = val;
          end
          bus.MOC = 1'b1;
          cnt     = 0;
        end else begin
          cnt++;
        end
      end else if (!bus.MOV && bus.MOC) begin
        if (cnt >= rel_delay) begin
          bus.MOC = 1'b0;
          cnt     = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_req(input string nm, input bit w, input logic [2:0] ms,
                        input logic [31:0] a, input logic [31:0] wd, input int md,
                        input int rdl, input bit hold, input bit use_exp,
                        input logic [1:0] xerr, input logic [31:0] xrd);
    logic [1:0]  merr;
    logic [31:0] mrd;
    logic [1:0]  e;
    logic [31:0] r;
    int          k, movc, elat, emov;
    bit          got, hbad;
    model(w, ms, a, wd, merr, mrd);
    e    = use_exp ? xerr : merr;
    r    = use_exp ? xrd  : mrd;
    elat = (e == 2'b01 || e == 2'b11) ? 1 : (e == 2'b10) ? 18 : 4 + md + rdl;
    emov = (e == 2'b01 || e == 2'b11) ? 0 : (e == 2'b10) ? 16 : md + 1;
    moc_delay = md;
    rel_delay = rdl;
    @(negedge CLK);
    chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_write = w;
    bus.req_ms    = ms;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge CLK);
    #1;
    if (hold) bus.req_addr = a ^ 32'h4;
    else      bus.req_valid = 1'b0;
    k = 0; movc = 0; got = 1'b0; hbad = 1'b0;
    while (!got && k < 200) begin
      @(negedge CLK);
      k++;
      if (bus.MOV) begin
        movc++;
        if (bus.Address !== a || bus.ReadWrite !== !w || bus.MS_2_0 !== ms || bus.DataIn !== wd)
          hbad = 1'b1;
      end
      if (bus.rsp_valid) got = 1'b1;
    end
    bus.req_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s rsp_wait: no rsp_valid within 200 cycles", nm);
    end else begin
      chk({nm, " err"},     32'(bus.rsp_err), 32'(e));
      chk({nm, " rdata"},   bus.rsp_rdata,    r);
      chk({nm, " latency"}, 32'(k),           32'(elat));
      chk({nm, " movcyc"},  32'(movc),        32'(emov));
      chk({nm, " busheld"}, 32'(hbad),        32'd0);
    end
    @(negedge CLK);
    chk({nm, " pulse"}, 32'(bus.rsp_valid), 32'd0);
    $display("txn %s w=%0d ms=%b addr=%h wd=%h err=%0d rdata=%h lat=%0d mov=%0d",
             nm, w, ms, a, wd, bus.rsp_err, bus.rsp_rdata, k, movc);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs [20];
    int          k;
    bit          seen;
    logic [7:0]  b;
    bit          rw;
    logic [2:0]  rms;
    logic [31:0] raddr;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_ms    = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom());
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    ram_mem[1] = 8'h85;
    ref_mem[1] = 8'h85;

    //         w     ms      addr           wdata          md rd hold err    rdata
    vecs[0]  = '{1'b0, 3'b100, 32'd1,         32'd0,         0, 0, 1'b0, 2'b00, 32'hFFFFFF85};
    vecs[1]  = '{1'b0, 3'b000, 32'd1,         32'd0,         1, 2, 1'b0, 2'b00, 32'h00000085};
    vecs[2]  = '{1'b1, 3'b001, 32'd10,        32'h0000FFFF,  0, 0, 1'b0, 2'b00, 32'h00000000};
    vecs[3]  = '{1'b0, 3'b001, 32'd10,        32'd0,         2, 1, 1'b0, 2'b00, 32'h0000FFFF};
    vecs[4]  = '{1'b0, 3'b101, 32'd10,        32'd0,         0, 0, 1'b0, 2'b00, 32'hFFFFFFFF};
    vecs[5]  = '{1'b0, 3'b010, 32'd253,       32'd0,         0, 0, 1'b0, 2'b01, 32'h00000000};
    vecs[6]  = '{1'b1, 3'b010, 32'd252,       32'h12345678,  1, 0, 1'b0, 2'b00, 32'h00000000};
    vecs[7]  = '{1'b0, 3'b010, 32'd252,       32'd0,         3, 1, 1'b1, 2'b00, 32'h12345678};
    vecs[8]  = '{1'b0, 3'b011, 32'd0,         32'd0,         0, 0, 1'b0, 2'b11, 32'h00000000};
    vecs[9]  = '{1'b1, 3'b011, 32'd0,         32'h55AA55AA,  0, 0, 1'b0, 2'b11, 32'h00000000};
    vecs[10] = '{1'b1, 3'b000, 32'd255,       32'hFFFFFFAB,  0, 1, 1'b0, 2'b00, 32'h00000000};
    vecs[11] = '{1'b0, 3'b000, 32'd255,       32'd0,         0, 0, 1'b0, 2'b00, 32'h000000AB};
    vecs[12] = '{1'b0, 3'b100, 32'd255,       32'd0,         2, 2, 1'b0, 2'b00, 32'hFFFFFFAB};
    vecs[13] = '{1'b0, 3'b001, 32'd255,       32'd0,         0, 0, 1'b0, 2'b01, 32'h00000000};
    vecs[14] = '{1'b0, 3'b000, 32'hFFFFFFFF,  32'd0,         0, 0, 1'b0, 2'b01, 32'h00000000};
    vecs[15] = '{1'b0, 3'b010, 32'hFFFFFFFE,  32'd0,         0, 0, 1'b0, 2'b01, 32'h00000000};
    vecs[16] = '{1'b1, 3'b010, 32'd1,         32'hDEADBEEF,  0, 0, 1'b0, 2'b00, 32'h00000000};
    vecs[17] = '{1'b0, 3'b010, 32'd1,         32'd0,         1, 1, 1'b0, 2'b00, 32'hDEADBEEF};
    vecs[18] = '{1'b0, 3'b100, 32'd2,         32'd0,         0, 0, 1'b0, 2'b00, 32'hFFFFFFAD};
    vecs[19] = '{1'b0, 3'b101, 32'd3,         32'd0,         0, 2, 1'b1, 2'b00, 32'hFFFFBEEF};

    // Reset values while RST_N is held low.
    repeat (3) @(negedge CLK);
    chk("rst MOV",       32'(bus.MOV),       32'd0);
    chk("rst ReadWrite", 32'(bus.ReadWrite), 32'd1);
    chk("rst MS_2_0",    32'(bus.MS_2_0),    32'd0);
    chk("rst Address",   bus.Address,        32'd0);
    chk("rst DataIn",    bus.DataIn,         32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata,      32'd0);
    chk("rst rsp_err",   32'(bus.rsp_err),   32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 20; i++)
      do_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].ms, vecs[i].addr, vecs[i].wd,
             vecs[i].md, vecs[i].rd, vecs[i].hold, 1'b1, vecs[i].err, vecs[i].rdata);

    // Reset in the middle of an ACCESS phase aborts the load silently.
    moc_delay = 6;
    rel_delay = 0;
    @(negedge CLK);
    bus.req_write = 1'b0;
    bus.req_ms    = 3'b010;
    bus.req_addr  = 32'd0;
    bus.req_valid = 1'b1;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    k = 0;
    while (!bus.MOV && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("abort mov_up", 32'(bus.MOV), 32'd1);
    #3 RST_N = 1'b0;
    #1;
    chk("abort mov_async", 32'(bus.MOV),       32'd0);
    chk("abort ready",     32'(bus.req_ready), 32'd1);
    chk("abort address",   bus.Address,        32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.rsp_valid || bus.MOV) seen = 1'b1;
    end
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (bus.rsp_valid || bus.MOV) seen = 1'b1;
    end
    chk("abort no_rsp",     32'(seen),          32'd0);
    chk("abort ready_post", 32'(bus.req_ready), 32'd1);
    $display("txn abort: reset during ACCESS, response suppressed=%0d", !seen);
    do_req("post_abort", 1'b0, 3'b000, 32'd1, 32'd0, 0, 0, 1'b0, 1'b0, 2'b00, 32'd0);

`ifdef MEM_TIMEOUT_EN
    ram_stuck = 1'b1;
    do_req("timeout", 1'b0, 3'b010, 32'd0, 32'd0, 0, 0, 1'b0, 1'b1, 2'b10, 32'd0);
    ram_stuck = 1'b0;
    do_req("post_timeout", 1'b0, 3'b010, 32'd4, 32'd0, 0, 0, 1'b0, 1'b0, 2'b00, 32'd0);
`endif

    for (int i = 0; i < 80; i++) begin
      rw  = 1'($urandom_range(0, 1));
      rms = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       raddr = $urandom();
        1:       raddr = 32'd250 + 32'($urandom_range(0, 9));
        default: raddr = 32'($urandom_range(0, 255));
      endcase
      do_req($sformatf("rnd%0d", i), rw, rms, raddr, $urandom(),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             ($urandom_range(0, 7) == 0), 1'b0, 2'b00, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
